pipeline_ctl_chain: RTL and testbench

Parametrised control-word pipeline for the pipelined core. It carries decoded control words from decode through DEPTH registered stages (EX, MEM, WB by default). Each stage has its own valid bit, per-stage stall and flush, and automatic bubble insertion. Retire and bubble counters are included for performance monitoring.

---
 rtl/pipeline_ctl_chain.sv | 104 ++++++++++
 tb/tb_pipeline_ctl_chain.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctl_chain.sv
// Control-word pipeline from decode through DEPTH registered stages, with
// per-stage stall/flush, automatic bubble insertion and retire/bubble counters.
module pipeline_ctl_stage #(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] NOP_WORD = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             hold,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_word,
  output logic             valid,
  output logic [WIDTH-1:0] word
);
  // Invalid entries always carry NOP_WORD, so the word mux keys off up_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      word  <= NOP_WORD;
    end else if (flush) begin
      valid <= 1'b0;
      word  <= NOP_WORD;
    end else if (!hold) begin
      valid <= up_valid;
      word  <= up_valid ? up_word : NOP_WORD;
    end
  end
endmodule

module pipeline_ctl_chain #(
  parameter int               WIDTH    = 16,
  parameter int               DEPTH    = 3,
  parameter logic [WIDTH-1:0] NOP_WORD = '0,
  parameter int               CNT_W    = 32
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_in_valid,
  input  logic [WIDTH-1:0]       i_in_word,
  input  logic [DEPTH-1:0]       i_stall,
  input  logic [DEPTH-1:0]       i_flush,
  input  logic                   i_cnt_clear,
  output logic                   o_in_ready,
  output logic [DEPTH*WIDTH-1:0] o_word,
  output logic [DEPTH-1:0]       o_valid,
  output logic                   o_retire,
  output logic [CNT_W-1:0]       o_retire_cnt,
  output logic [CNT_W-1:0]       o_bubble_cnt
);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [DEPTH-1:0]            hold;
  logic [DEPTH-1:0]            up_valid;
  logic [DEPTH-1:0][WIDTH-1:0] up_word;
  logic [DEPTH-1:0][WIDTH-1:0] words;

  // hold is monotonic toward decode, so "upstream held, this stage free"
  // reduces to masking the upstream valid with the upstream hold.
  always_comb begin
    hold     = '0;
    up_valid = '0;
    up_word  = '0;
    hold[DEPTH-1] = i_stall[DEPTH-1];
    for (int s = DEPTH-2; s >= 0; s--)
      hold[s] = i_stall[s] | hold[s+1];
    up_valid[0] = i_in_valid;
    up_word[0]  = i_in_word;
    for (int s = 1; s < DEPTH; s++) begin
      up_valid[s] = o_valid[s-1] & ~hold[s-1];
      up_word[s]  = words[s-1];
    end
  end

  for (genvar s = 0; s < DEPTH; s++) begin : g_stage
    pipeline_ctl_stage #(.WIDTH(WIDTH), .NOP_WORD(NOP_WORD)) u_stage (
      .clk     (i_clk),
      .rst_n   (i_reset_n),
      .flush   (i_flush[s]),
      .hold    (hold[s]),
      .up_valid(up_valid[s]),
      .up_word (up_word[s]),
      .valid   (o_valid[s]),
      .word    (words[s])
    );
  end

  assign o_word     = words;
  assign o_in_ready = ~hold[0];
  assign o_retire   = o_valid[DEPTH-1] & ~i_stall[DEPTH-1];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_retire_cnt <= '0;
      o_bubble_cnt <= '0;
    end else if (i_cnt_clear) begin
      o_retire_cnt <= '0;
      o_bubble_cnt <= '0;
    end else begin
      if (o_retire)          o_retire_cnt <= o_retire_cnt + CNT_ONE;
      if (!o_valid[DEPTH-1]) o_bubble_cnt <= o_bubble_cnt + CNT_ONE;
    end
  end
endmodule

// File: tb/tb_pipeline_ctl_chain.sv
// Directed bench for pipeline_ctl_chain (WIDTH=16, DEPTH=3, CNT_W=4) with a
// retire-order scoreboard fed from accepted decode words.
module tb_pipeline_ctl_chain;
  localparam int W = 16, D = 3, CW = 4;

  logic          i_clk = 1'b0;
  logic          i_reset_n;
  logic          i_in_valid;
  logic [W-1:0]  i_in_word;
  logic [D-1:0]  i_stall, i_flush;
  logic          i_cnt_clear;
  logic          o_in_ready, o_retire;
  logic [D*W-1:0] o_word;
  logic [D-1:0]  o_valid;
  logic [CW-1:0] o_retire_cnt, o_bubble_cnt;

  pipeline_ctl_chain #(.WIDTH(W), .DEPTH(D), .NOP_WORD(16'h0000), .CNT_W(CW)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_in_valid(i_in_valid), .i_in_word(i_in_word),
    .i_stall(i_stall), .i_flush(i_flush), .i_cnt_clear(i_cnt_clear),
    .o_in_ready(o_in_ready), .o_word(o_word), .o_valid(o_valid), .o_retire(o_retire),
    .o_retire_cnt(o_retire_cnt), .o_bubble_cnt(o_bubble_cnt)
  );

  always #5 i_clk = ~i_clk;

  int nchk = 0, nerr = 0;
  logic [W-1:0] sb[$];
  logic [W-1:0] drop;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] wd(input int s);
    return o_word[s*W +: W];
  endfunction

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  // Negedge view: what is consumed / retired at the coming rising edge.
  always @(negedge i_clk) begin
    if (i_reset_n) begin
      if (o_retire) begin
        if (sb.size() == 0) begin
          nchk++;
          nerr++;
          $error("FAIL retire_unexpected: observed %0h expected none", wd(D-1));
        end else
          chk("retire_word", wd(D-1), sb.pop_front());
      end
      if (i_in_valid && o_in_ready) sb.push_back(i_in_word);
    end
  end

  initial begin
    i_reset_n = 1'b0; i_in_valid = 1'b0; i_in_word = '0;
    i_stall = '0; i_flush = '0; i_cnt_clear = 1'b0;
    #1;
    chk("rst_valid", o_valid, 3'b000);
    chk("rst_word", o_word, 48'h0);
    chk("rst_rcnt", o_retire_cnt, 4'd0);
    chk("rst_bcnt", o_bubble_cnt, 4'd0);
    chk("rst_ready", o_in_ready, 1'b1);
    chk("rst_retire", o_retire, 1'b0);
    tick; tick;
    i_reset_n = 1'b1;

    // straight flow
    i_in_valid = 1'b1; i_in_word = 16'h1111; i_cnt_clear = 1'b1; tick;
    i_cnt_clear = 1'b0; i_in_word = 16'h2222; tick;
    i_in_word = 16'h3333; tick;
    chk("t1_s2_word", wd(2), 16'h1111);
    chk("t1_valid", o_valid, 3'b111);
    i_in_valid = 1'b0; #1;
    chk("t1_retire_a", o_retire, 1'b1);
    tick;
    chk("t1_retire_b", o_retire, 1'b1);
    chk("t1_s2_word_b", wd(2), 16'h2222);
    tick;
    chk("t1_retire_c", o_retire, 1'b1);
    tick;
    chk("t1_retire_end", o_retire, 1'b0);
    chk("t1_rcnt", o_retire_cnt, 4'd3);
    chk("t1_bcnt", o_bubble_cnt, 4'd2);
    chk("t1_empty", o_valid, 3'b000);

    // load-use stall on stage 0
    i_in_valid = 1'b1; i_in_word = 16'h1212; tick;
    i_in_word = 16'h2222; tick;
    i_stall = 3'b001; i_in_word = 16'h3434; #1;
    chk("t2_ready_low", o_in_ready, 1'b0);
    tick;
    chk("t2_s0_hold", wd(0), 16'h2222);
    chk("t2_valid", o_valid, 3'b101);
    chk("t2_s1_bubble", wd(1), 16'h0000);
    chk("t2_bcnt", o_bubble_cnt, 4'd5);
    i_stall = 3'b000; #1;
    chk("t2_ready_high", o_in_ready, 1'b1);
    tick;
    chk("t2_s0_resume", wd(0), 16'h3434);
    chk("t2_s1_resume", wd(1), 16'h2222);
    chk("t2_valid_resume", o_valid, 3'b011);
    chk("t2_rcnt", o_retire_cnt, 4'd4);

    // downstream stall with a full pipe
    i_in_word = 16'h5656; tick;
    chk("t3_full", o_valid, 3'b111);
    i_stall = 3'b100; i_in_word = 16'h7878; #1;
    chk("t3_retire_low", o_retire, 1'b0);
    chk("t3_ready_low", o_in_ready, 1'b0);
    tick; tick;
    chk("t3_valid", o_valid, 3'b111);
    chk("t3_words", o_word, {16'h2222, 16'h3434, 16'h5656});
    chk("t3_rcnt", o_retire_cnt, 4'd4);
    chk("t3_bcnt", o_bubble_cnt, 4'd6);
    i_stall = 3'b000; tick;
    chk("t3_rcnt_after", o_retire_cnt, 4'd5);

    // flush and stall together on stage 0
    i_flush = 3'b001; i_stall = 3'b001; i_in_word = 16'h9a9a; #1;
    chk("t4_ready_low", o_in_ready, 1'b0);
    tick;
    chk("t4_valid", o_valid, 3'b100);
    chk("t4_words", o_word, {16'h5656, 16'h0000, 16'h0000});
    chk("t4_rcnt", o_retire_cnt, 4'd6);
    if (sb.size() != 0) drop = sb.pop_back();
    i_flush = 3'b000; i_stall = 3'b000; i_in_valid = 1'b0;
    tick; tick;
    chk("t4_rcnt_drain", o_retire_cnt, 4'd7);
    chk("t4_bcnt_drain", o_bubble_cnt, 4'd7);
    chk("t4_empty", o_valid, 3'b000);
    chk("t4_sb_empty", sb.size(), 0);

    // async reset mid-stream
    i_in_valid = 1'b1; i_in_word = 16'hb001; tick;
    i_in_word = 16'hb002; tick;
    i_in_word = 16'hb003; tick;
    chk("t5_full", o_valid, 3'b111);
    chk("t5_bcnt", o_bubble_cnt, 4'd10);
    #2; i_reset_n = 1'b0; sb.delete(); #1;
    chk("t5_rst_valid", o_valid, 3'b000);
    chk("t5_rst_word", o_word, 48'h0);
    chk("t5_rst_rcnt", o_retire_cnt, 4'd0);
    chk("t5_rst_bcnt", o_bubble_cnt, 4'd0);
    chk("t5_rst_ready", o_in_ready, 1'b1);
    i_in_word = 16'hb004; tick;
    chk("t5_rst_edge", o_valid, 3'b000);
    i_reset_n = 1'b1; #1;
    chk("t5_release", o_valid, 3'b000);
    tick;
    chk("t5_first_load", o_valid, 3'b001);
    chk("t5_first_word", wd(0), 16'hb004);
    chk("t5_bcnt", o_bubble_cnt, 4'd1);

    // counter wrap and clear-vs-increment priority
    i_cnt_clear = 1'b1; i_in_word = 16'hc000; tick;
    i_cnt_clear = 1'b0;
    chk("t6_clear", o_retire_cnt, 4'd0);
    for (int i = 1; i <= 16; i++) begin
      i_in_word = 16'hc000 + 16'(i);
      tick;
    end
    chk("t6_rcnt_15", o_retire_cnt, 4'd15);
    chk("t6_bcnt", o_bubble_cnt, 4'd1);
    i_in_word = 16'hc011; tick;
    chk("t6_wrap", o_retire_cnt, 4'd0);
    i_cnt_clear = 1'b1; i_in_word = 16'hc012; #1;
    chk("t6_retire_hi", o_retire, 1'b1);
    tick;
    chk("t6_clear_prio", o_retire_cnt, 4'd0);
    i_cnt_clear = 1'b0; i_in_word = 16'hc013; tick;
    chk("t6_inc_after", o_retire_cnt, 4'd1);
    chk("t6_bcnt_after", o_bubble_cnt, 4'd0);
    i_in_valid = 1'b0;
    tick; tick; tick;
    chk("end_empty", o_valid, 3'b000);
    chk("end_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end
endmodule
